// File: rtl/notas_pkg.sv
// Shared constants for the note generator: FSM states, LFSR seed/taps and
// the initial lane patterns, plus the pattern-from-LFSR helper.
package notas_pkg;

   typedef enum logic [1:0] {
      ESPERA    = 2'd0,
      CORRIENDO = 2'd1,
      DETENIDO  = 2'd2
   } estado_t;

   localparam logic [15:0] LFSR_SEMILLA = 16'hACE1;
   // Taps 16,14,13,11 counted from 1, i.e. bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;

   // Lane k initial pattern lives in bits [5k +: 5].
   localparam logic [19:0] PATRONES_INI = {5'b01000, 5'b00100, 5'b00010, 5'b00001};

   function automatic logic [15:0] lfsr_sig(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction

   // A lane must never show an empty pattern.
   function automatic logic [4:0] patron_de(input logic [4:0] bits);
      return (bits == 5'd0) ? 5'd1 : bits;
   endfunction

endpackage

// File: rtl/carril_nota.sv
// One lane: position counter that wraps at ALTO-1 and reloads its drum
// pattern from the LFSR on every wrap.
module carril_nota
   import notas_pkg::*;
#(
   parameter int          ALTO    = 480,
   parameter int          POS_INI = 0,
   parameter logic [4:0]  PAT_INI = 5'b00001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cargar_i,
   input  logic       avanzar_i,
   input  logic [4:0] lfsr_i,
   output logic [9:0] pos_o,
   output logic [4:0] linea_o
);

   localparam logic [9:0] ULTIMA = 10'(ALTO - 1);
   localparam logic [9:0] INICIO = 10'(POS_INI);

   logic [9:0] pos_q, pos_d;
   logic [4:0] linea_q, linea_d;

   always_comb begin
      pos_d   = pos_q;
      linea_d = linea_q;
      if (cargar_i) begin
         pos_d   = INICIO;
         linea_d = PAT_INI;
      end else if (avanzar_i) begin
         if (pos_q == ULTIMA) begin
            pos_d   = '0;
            linea_d = patron_de(lfsr_i);
         end else begin
            pos_d = pos_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q   <= INICIO;
         linea_q <= PAT_INI;
      end else begin
         pos_q   <= pos_d;
         linea_q <= linea_d;
      end
   end

   assign pos_o   = pos_q;
   assign linea_o = linea_q;

endmodule

// File: rtl/generador_notas.sv
// Four-lane falling-note generator with start/stop FSM and tick divider.
// Define ACELERACION_EN to shorten the tick period as lanes keep wrapping.
module generador_notas
   import notas_pkg::*;
#(
   parameter int DIV_TICK   = 20000,
   parameter int ALTO       = 480,
   parameter int SEPARACION = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       perdio,
   output logic [9:0] posL1,
   output logic [9:0] posL2,
   output logic [9:0] posL3,
   output logic [9:0] posL4,
   output logic [4:0] linea1,
   output logic [4:0] linea2,
   output logic [4:0] linea3,
   output logic [4:0] linea4,
   output logic       activo
);

   estado_t     estado_q;
   logic [15:0] div_q;
   logic [15:0] lfsr_q;
   logic        activo_q;
   logic [15:0] periodo;
   logic        tick;
   logic        avanzar;
   logic        cargar;
   logic [9:0]  pos_w [4];
   logic [4:0]  lin_w [4];

`ifdef ACELERACION_EN
   logic [2:0] nivel_q;
   logic [2:0] cnt_wrap_q;
   logic [2:0] n_wraps;
   logic [3:0] suma;

   assign periodo = 16'(DIV_TICK) - {12'd0, nivel_q, 1'b0};

   always_comb begin
      n_wraps = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (avanzar && (pos_w[k] == 10'(ALTO - 1)))
            n_wraps = n_wraps + 3'd1;
      end
      suma = {1'b0, cnt_wrap_q} + {1'b0, n_wraps};
   end

   // Carry out of the 3-bit wrap accumulator marks each group of 8 wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         nivel_q    <= '0;
         cnt_wrap_q <= '0;
      end else if (avanzar) begin
         cnt_wrap_q <= suma[2:0];
         if (suma[3] && (nivel_q != 3'd7))
            nivel_q <= nivel_q + 3'd1;
      end
   end
`else
   assign periodo = 16'(DIV_TICK);
`endif

   assign tick    = (estado_q == CORRIENDO) && (div_q == periodo - 16'd1);
   assign avanzar = tick && !perdio;
   assign cargar  = (estado_q == DETENIDO) && iniciar;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= ESPERA;
         div_q    <= '0;
         lfsr_q   <= LFSR_SEMILLA;
         activo_q <= 1'b0;
      end else begin
         case (estado_q)
            ESPERA: begin
               if (iniciar) begin
                  estado_q <= CORRIENDO;
                  div_q    <= '0;
                  activo_q <= 1'b1;
               end
            end
            CORRIENDO: begin
               lfsr_q <= lfsr_sig(lfsr_q);
               if (perdio) begin
                  estado_q <= DETENIDO;
                  activo_q <= 1'b0;
               end else if (tick) begin
                  div_q <= '0;
               end else begin
                  div_q <= div_q + 16'd1;
               end
            end
            DETENIDO: begin
               if (iniciar) begin
                  estado_q <= CORRIENDO;
                  div_q    <= '0;
                  activo_q <= 1'b1;
               end
            end
            default: begin
               estado_q <= ESPERA;
               activo_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_carril
      carril_nota #(
         .ALTO    (ALTO),
         .POS_INI (k * SEPARACION),
         .PAT_INI (PATRONES_INI[5*k +: 5])
      ) u_carril (
         .clk       (clk),
         .reset     (reset),
         .cargar_i  (cargar),
         .avanzar_i (avanzar),
         .lfsr_i    (lfsr_q[4:0]),
         .pos_o     (pos_w[k]),
         .linea_o   (lin_w[k])
      );
   end

   assign posL1  = pos_w[0];
   assign posL2  = pos_w[1];
   assign posL3  = pos_w[2];
   assign posL4  = pos_w[3];
   assign linea1 = lin_w[0];
   assign linea2 = lin_w[1];
   assign linea3 = lin_w[2];
   assign linea4 = lin_w[3];
   assign activo = activo_q;

endmodule

// File: tb/tb_generador_notas.sv
// Self-checking bench for generador_notas against a behavioural game model.
module tb_generador_notas;

   localparam int DIV  = 16;
   localparam int ALTO = 480;
   localparam int SEP  = 120;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       perdio = 1'b0;
   logic [9:0] posL1, posL2, posL3, posL4;
   logic [4:0] linea1, linea2, linea3, linea4;
   logic       activo;

   int errors = 0;
   int checks = 0;

   // Reference model of the game state
   bit m_run;
   bit m_stopped;
   int m_div;
   int m_pos [4];
   int m_lin [4];
   int m_lfsr;
   int m_wraps;

   always #5 clk = ~clk;

   generador_notas #(
      .DIV_TICK   (DIV),
      .ALTO       (ALTO),
      .SEPARACION (SEP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .iniciar (iniciar),
      .perdio  (perdio),
      .posL1   (posL1),
      .posL2   (posL2),
      .posL3   (posL3),
      .posL4   (posL4),
      .linea1  (linea1),
      .linea2  (linea2),
      .linea3  (linea3),
      .linea4  (linea4),
      .activo  (activo)
   );

   function automatic logic [9:0] dut_pos(input int k);
      case (k)
         0: return posL1;
         1: return posL2;
         2: return posL3;
         default: return posL4;
      endcase
   endfunction

   function automatic logic [4:0] dut_lin(input int k);
      case (k)
         0: return linea1;
         1: return linea2;
         2: return linea3;
         default: return linea4;
      endcase
   endfunction

   function automatic int lfsr_next(input int l);
      int b;
      b = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) & 'hFFFF) | b;
   endfunction

   function automatic int pat_of(input int l);
      int p;
      p = l % 32;
      return (p == 0) ? 1 : p;
   endfunction

   function automatic int level();
`ifdef ACELERACION_EN
      return (m_wraps / 8 > 7) ? 7 : m_wraps / 8;
`else
      return 0;
`endif
   endfunction

   function automatic int period();
      return DIV - 2 * level();
   endfunction

   task automatic model_reload();
      for (int k = 0; k < 4; k++) begin
         m_pos[k] = k * SEP;
         m_lin[k] = 1 << k;
      end
   endtask

   task automatic model_update(input bit r, input bit ini, input bit per);
      bit t;
      if (r) begin
         m_run = 0; m_stopped = 0; m_div = 0; m_lfsr = 'hACE1; m_wraps = 0;
         model_reload();
      end else if (!m_run) begin
         if (ini) begin
            if (m_stopped) model_reload();
            m_run = 1; m_stopped = 0; m_div = 0;
         end
      end else begin
         t = (m_div == period() - 1);
         if (per) begin
            m_run = 0; m_stopped = 1;
         end else if (t) begin
            for (int k = 0; k < 4; k++) begin
               if (m_pos[k] == ALTO - 1) begin
                  m_pos[k] = 0;
                  m_lin[k] = pat_of(m_lfsr);
                  m_wraps++;
               end else begin
                  m_pos[k] = m_pos[k] + 1;
               end
            end
            m_div = 0;
         end else begin
            m_div++;
         end
         m_lfsr = lfsr_next(m_lfsr);
      end
   endtask

   task automatic cycle(input bit r, input bit ini, input bit per);
      reset = r; iniciar = ini; perdio = per;
      @(posedge clk);
      model_update(r, ini, per);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 0, 0);
      cycle(1, 1, 0);
      checks++;
      if (activo !== 1'b0) begin
         errors++; $display("FAIL reset_activo: got %b expected 0", activo);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_pos(k) !== 10'(k * SEP)) begin
            errors++; $display("FAIL reset_pos%0d: got %0d expected %0d", k + 1, dut_pos(k), k * SEP);
         end
         checks++;
         if (dut_lin(k) !== 5'(1 << k)) begin
            errors++; $display("FAIL reset_lin%0d: got %b expected %b", k + 1, dut_lin(k), 5'(1 << k));
         end
      end
   endtask

   task automatic test_start();
      cycle(1, 0, 0);
      cycle(0, 1, 0);
      checks++;
      if (activo !== 1'b1) begin
         errors++; $display("FAIL start_activo: got %b expected 1", activo);
      end
      repeat (15) cycle(0, 0, 0);
      checks++;
      if (posL1 !== 10'd0) begin
         errors++; $display("FAIL start_pos1_early: got %0d expected 0", posL1);
      end
      cycle(0, 0, 0);
      checks++;
      if (posL1 !== 10'd1) begin
         errors++; $display("FAIL start_pos1: got %0d expected 1", posL1);
      end
      checks++;
      if (posL2 !== 10'd121) begin
         errors++; $display("FAIL start_pos2: got %0d expected 121", posL2);
      end
   endtask

   task automatic test_wrap();
      int n;
      n = 0;
      while (posL4 !== 10'd479 && n < 3000) begin cycle(0, 0, 0); n++; end
      checks++;
      if (posL4 !== 10'd479) begin
         errors++; $display("FAIL wrap_reach479: got %0d expected 479", posL4);
      end
      n = 0;
      while (posL4 === 10'd479 && n < 64) begin cycle(0, 0, 0); n++; end
      checks++;
      if (posL4 !== 10'd0) begin
         errors++; $display("FAIL wrap_pos4: got %0d expected 0", posL4);
      end
      checks++;
      if (linea4 !== m_lin[3][4:0]) begin
         errors++; $display("FAIL wrap_lin4: got %b expected %b", linea4, m_lin[3][4:0]);
      end
      checks++;
      if (linea4 === 5'd0) begin
         errors++; $display("FAIL wrap_lin4_nonzero: got %b expected nonzero", linea4);
      end
      checks++;
      if (posL3 !== m_pos[2][9:0]) begin
         errors++; $display("FAIL wrap_pos3: got %0d expected %0d", posL3, m_pos[2]);
      end
   endtask

   task automatic test_stop();
      logic [9:0] held [4];
      repeat ($urandom_range(5, 40)) cycle(0, 0, 0);
      cycle(0, 0, 1);
      checks++;
      if (activo !== 1'b0) begin
         errors++; $display("FAIL stop_activo: got %b expected 0", activo);
      end
      for (int k = 0; k < 4; k++) held[k] = m_pos[k][9:0];
      for (int i = 0; i < 100; i++) cycle(0, 0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_pos(k) !== held[k]) begin
            errors++; $display("FAIL stop_frozen%0d: got %0d expected %0d", k + 1, dut_pos(k), held[k]);
         end
      end
      cycle(0, 1, 0);
      checks++;
      if (activo !== 1'b1) begin
         errors++; $display("FAIL restart_activo: got %b expected 1", activo);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_pos(k) !== 10'(k * SEP)) begin
            errors++; $display("FAIL restart_pos%0d: got %0d expected %0d", k + 1, dut_pos(k), k * SEP);
         end
         checks++;
         if (dut_lin(k) !== 5'(1 << k)) begin
            errors++; $display("FAIL restart_lin%0d: got %b expected %b", k + 1, dut_lin(k), 5'(1 << k));
         end
      end
   endtask

   task automatic test_perdio_tick();
      logic [9:0] held [4];
      int n;
      repeat ($urandom_range(20, 50)) cycle(0, 0, 0);
      n = 0;
      while (!(m_run && m_div == period() - 1) && n < 64) begin cycle(0, 0, 0); n++; end
      for (int k = 0; k < 4; k++) held[k] = dut_pos(k);
      cycle(0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_pos(k) !== held[k]) begin
            errors++; $display("FAIL perdio_tick_pos%0d: got %0d expected %0d", k + 1, dut_pos(k), held[k]);
         end
      end
      checks++;
      if (activo !== 1'b0) begin
         errors++; $display("FAIL perdio_tick_activo: got %b expected 0", activo);
      end
      cycle(0, 1, 0);
   endtask

   task automatic test_reset_mid();
      repeat ($urandom_range(20, 60)) cycle(0, 0, 0);
      cycle(1, 1, 0);
      checks++;
      if (activo !== 1'b0) begin
         errors++; $display("FAIL midreset_activo: got %b expected 0", activo);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_pos(k) !== 10'(k * SEP) || dut_lin(k) !== 5'(1 << k)) begin
            errors++;
            $display("FAIL midreset_lane%0d: got pos %0d lin %b expected pos %0d lin %b",
                     k + 1, dut_pos(k), dut_lin(k), k * SEP, 5'(1 << k));
         end
      end
      cycle(0, 0, 0);
      checks++;
      if (activo !== 1'b0) begin
         errors++; $display("FAIL midreset_iniciar_ignored: got %b expected 0", activo);
      end
   endtask

   task automatic test_random();
      bit r, ini, per;
      cycle(0, 1, 0);
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 199) == 0);
         ini = ($urandom_range(0, 29) == 0);
         per = ($urandom_range(0, 59) == 0);
         cycle(r, ini, per);
         checks++;
         if (activo !== 1'(m_run)) begin
            errors++; $display("FAIL rand_activo cyc %0d: got %b expected %b", i, activo, m_run);
         end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_pos(k) !== m_pos[k][9:0]) begin
               errors++; $display("FAIL rand_pos%0d cyc %0d: got %0d expected %0d", k + 1, i, dut_pos(k), m_pos[k]);
            end
            checks++;
            if (dut_lin(k) !== m_lin[k][4:0]) begin
               errors++; $display("FAIL rand_lin%0d cyc %0d: got %b expected %b", k + 1, i, dut_lin(k), m_lin[k][4:0]);
            end
         end
      end
   endtask

`ifdef ACELERACION_EN
   task automatic test_aceleracion();
      int need [2];
      int exp_sp [2];
      int n, sp;
      logic [9:0] p0;
      need[0] = 8;  exp_sp[0] = 14;
      need[1] = 56; exp_sp[1] = 2;
      cycle(1, 0, 0);
      cycle(0, 1, 0);
      for (int ph = 0; ph < 2; ph++) begin
         n = 0;
         while (m_wraps < need[ph] && n < 90000) begin cycle(0, 0, 0); n++; end
         checks++;
         if (m_wraps < need[ph]) begin
            errors++; $display("FAIL accel_reach_wraps: got %0d expected %0d", m_wraps, need[ph]);
         end
         for (int rep = 0; rep < 3; rep++) begin
            p0 = posL1; n = 0;
            while (posL1 === p0 && n < 64) begin cycle(0, 0, 0); n++; end
            p0 = posL1; sp = 0;
            while (posL1 === p0 && sp < 64) begin cycle(0, 0, 0); sp++; end
            checks++;
            if (sp != exp_sp[ph]) begin
               errors++; $display("FAIL accel_spacing ph%0d: got %0d expected %0d", ph, sp, exp_sp[ph]);
            end
         end
         checks++;
         if (posL4 !== m_pos[3][9:0] || linea4 !== m_lin[3][4:0]) begin
            errors++; $display("FAIL accel_lane4: got %0d/%b expected %0d/%b", posL4, linea4, m_pos[3], m_lin[3][4:0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_start();
      test_wrap();
      test_stop();
      test_perdio_tick();
      test_reset_mid();
      test_random();
`ifdef ACELERACION_EN
      test_aceleracion();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/generador_notas.md
GENERADOR_NOTAS -- requirements
Module: generador_notas

Interface
REQ-001 SHALL have parameter DIV_TICK, default 20000, meaning clocks per position step (minimum 16).
REQ-002 SHALL have parameter ALTO, default 480, meaning the number of lane rows; positions run 0..ALTO-1.
REQ-003 SHALL have parameter SEPARACION, default 120, meaning the initial row offset between adjacent lanes.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port iniciar, input, 1 bit: start/restart request, sampled each clk.
REQ-007 SHALL have port perdio, input, 1 bit: game-over flag from the score stage.
REQ-008 SHALL have ports posL1..posL4, output, 10 bits each: current row of each lane's note block.
REQ-009 SHALL have ports linea1..linea4, output, 5 bits each: required drum pattern for each lane's note.
REQ-010 SHALL have port activo, output, 1 bit: high while in state CORRIENDO.

Function
REQ-011 SHALL implement FSM states ESPERA, CORRIENDO, DETENIDO.
REQ-012 SHALL transition ESPERA->CORRIENDO on iniciar=1, and CORRIENDO->DETENIDO on perdio=1; perdio has priority over tick in the same cycle.
REQ-013 SHALL, in DETENIDO on iniciar=1, reload initial positions and patterns and enter CORRIENDO next cycle.
REQ-014 SHALL generate a one-cycle tick every DIV_TICK clocks while in CORRIENDO; the divider clears on entry to CORRIENDO.
REQ-015 SHALL, on tick, increment each posLk by 1; when posLk=ALTO-1, the next value is 0 (wrap).
REQ-016 SHALL, on a lane wrap, load lineak with a new pattern in the same cycle posLk becomes 0.
REQ-017 SHALL take new patterns from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that advances every clk in CORRIENDO; pattern = lfsr[4:0], with 5'b00000 replaced by 5'b00001.
REQ-018 SHALL use initial positions posL1=0, posL2=SEPARACION, posL3=2*SEPARACION, posL4=3*SEPARACION; initial linea1..4 = 5'b00001, 5'b00010, 5'b00100, 5'b01000.
REQ-019 SHALL hold all positions, patterns, and the LFSR in ESPERA and DETENIDO.
REQ-020 SHALL guarantee each lane presents every value 0..ALTO-1 for exactly one tick period, so that downstream edge detection at 0 and ALTO-1 fires once per pass.
REQ-021 SHALL keep all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, on reset=1, set state ESPERA, initial positions and patterns per REQ-018, LFSR to seed, divider to 0, activo=0; reset overrides all other inputs.
REQ-023 SHALL, on reset asserted mid-CORRIENDO, restore all outputs to their reset values on the next clk edge.

Configuration
REQ-024 SHALL, with ACELERACION_EN defined, maintain a 3-bit level nivel (reset 0) that increments every 8 lane wraps, saturates at 7, and sets the tick period to DIV_TICK-2*nivel clocks.
REQ-025 SHALL, without ACELERACION_EN, keep the tick period fixed at DIV_TICK and omit the nivel logic.

Structure
REQ-026 SHALL place FSM state encodings, the LFSR seed and taps, and the initial-pattern constants in shared package notas_pkg.
REQ-027 SHALL implement each lane as sub-module carril_nota (position counter, wrap, pattern load), instantiated four times.

Verification
REQ-028 SHALL verify: reset, then DIV_TICK=16, iniciar pulse -> activo=1 next cycle; posL1 reaches 1 after 16 clocks and posL2=121.
REQ-029 SHALL verify: run until posL4 reaches 479, then one tick -> posL4=0, linea4 equals the LFSR-derived pattern, and linea4 is nonzero.
REQ-030 SHALL verify: perdio=1 mid-run -> activo=0 next cycle and positions frozen for 100 clocks; iniciar -> positions return to 0/120/240/360.
REQ-031 SHALL verify: perdio and tick in the same cycle -> no position change.
REQ-032 SHALL verify: reset asserted mid-run -> all outputs at reset values after one clk, and iniciar is ignored during that cycle.
REQ-033 SHALL verify, with ACELERACION_EN: after 8 wraps, tick spacing = 14 clocks; after 56 wraps, spacing = 2 clocks and stays there.
